// File: rtl/dso_host_pkg.sv
// Shared definitions for the DSO UART host command sequencer:
// FSM state encoding, acknowledge byte values and command opcodes.
package dso_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_TX_WAIT = 3'd2,
    S_RX_WAIT = 3'd3,
    S_RX_CLR  = 3'd4,
    S_FIN     = 3'd5
  } host_state_e;

  // Single-byte replies returned by the scope for write/config commands.
  localparam logic [7:0] ACK_BYTE  = 8'hA5;
  localparam logic [7:0] NACK_BYTE = 8'hEE;

  // Command opcodes (first byte of every command word).
  localparam logic [7:0] DUMP_CH      = 8'h01;
  localparam logic [7:0] CFG_GAIN     = 8'h02;
  localparam logic [7:0] CFG_TRIG_LVL = 8'h03;
  localparam logic [7:0] CFG_TRIG_POS = 8'h04;
  localparam logic [7:0] SET_DEC      = 8'h05;
  localparam logic [7:0] CFG_TRIG     = 8'h06;
  localparam logic [7:0] CAL_OFF      = 8'h07;
  localparam logic [7:0] EEP_WR       = 8'h08;
  localparam logic [7:0] EEP_RD       = 8'h09;

  // True when a byte is one of the defined command opcodes.
  function automatic logic is_opcode(input logic [7:0] op);
    return (op >= DUMP_CH) && (op <= EEP_RD);
  endfunction

endpackage

// File: rtl/dso_host_timeout.sv
// Inter-byte response timer: up-counter with synchronous clear, parallel
// load and a terminal-count flag raised when the count reaches
// TIMEOUT_CYC-1. The count holds at terminal count while enabled.
module dso_host_timeout #(
  parameter int TIMEOUT_CYC = 65536,
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  assign tc = (count == TC_VAL);

  // Count enabled cycles; clear has priority over load, load over count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {CW{1'b0}};
    end else if (clr) begin
      count <= {CW{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (en && !tc) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/dso_cmd_host_seq.sv
// Host-side command sequencer for the DSO UART link.
// Sends a CMD_BYTES-wide command MSB byte first through a byte-level UART
// transmitter, then collects resp_len response bytes from the byte-level
// receiver with an inter-byte timeout.
// Optional build macro DSO_CMD_HOST_ACK_CHECK_EN adds a sticky nack output
// that flags a single-byte response other than the ACK byte, or a timeout.
module dso_cmd_host_seq
  import dso_host_pkg::*;
#(
  parameter int CMD_BYTES   = 3,
  parameter int RESP_MAX    = 512,
  parameter int TIMEOUT_CYC = 65536,
  localparam int LEN_W      = $clog2(RESP_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*CMD_BYTES-1:0] cmd,
  input  logic [LEN_W-1:0]       resp_len,
  input  logic                   send_cmd,
  output logic                   busy,
  output logic [7:0]             tx_data,
  output logic                   trmt,
  input  logic                   tx_done,
  input  logic [7:0]             rx_data,
  input  logic                   rx_rdy,
  output logic                   clr_rx_rdy,
  output logic [7:0]             resp_byte,
  output logic                   resp_vld,
  output logic                   resp_last,
  output logic [LEN_W-1:0]       resp_cnt,
  output logic                   cmd_sent,
  output logic                   done,
  output logic                   timeout_err,
  output logic                   overrun_err
`ifdef DSO_CMD_HOST_ACK_CHECK_EN
  ,
  output logic                   nack
`endif
);

  localparam int CW  = 8 * CMD_BYTES;
  localparam int IW  = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [LEN_W-1:0] RESP_MAX_L = LEN_W'(RESP_MAX);
  localparam logic [IW-1:0]    LAST_IDX   = IW'(CMD_BYTES - 1);

  host_state_e      state;
  logic [CW-1:0]    cmd_sh;
  logic [IW-1:0]    byte_idx;
  logic [LEN_W-1:0] len_q;
  logic             tx_done_q;

  logic             tx_done_rise;
  logic             rx_take;
  logic             last_byte_done;
  logic [LEN_W-1:0] sat_len;
  logic [LEN_W-1:0] resp_cnt_nxt;
  logic             tmo_clr;
  logic             tmo_en;
  logic             tmo_tc;

  // Event decode: edge of tx_done, a fresh rx byte (ignoring the level still
  // visible while our own clear is in flight), and length saturation.
  always_comb begin
    tx_done_rise   = tx_done & ~tx_done_q;
    rx_take        = rx_rdy & ~clr_rx_rdy;
    last_byte_done = (state == S_TX_WAIT) && tx_done_rise && (byte_idx == LAST_IDX);
    resp_cnt_nxt   = resp_cnt + LEN_W'(1);
    if (resp_len > RESP_MAX_L) begin
      sat_len = RESP_MAX_L;
    end else begin
      sat_len = resp_len;
    end
  end

  // Timer restarts when the command finishes and on every captured byte;
  // it runs while waiting for a byte, including the post-capture gap.
  always_comb begin
    tmo_clr = last_byte_done || ((state == S_RX_WAIT) && rx_take);
    tmo_en  = ((state == S_RX_WAIT) && !rx_take) || (state == S_RX_CLR);
  end

  dso_host_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .load    (1'b0),
    .load_val({TCW{1'b0}}),
    .en      (tmo_en),
    .tc      (tmo_tc)
  );

  // Main sequencer: command serialisation, response capture, error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_sh      <= {CW{1'b0}};
      byte_idx    <= {IW{1'b0}};
      len_q       <= {LEN_W{1'b0}};
      tx_done_q   <= 1'b0;
      busy        <= 1'b0;
      tx_data     <= 8'h00;
      trmt        <= 1'b0;
      clr_rx_rdy  <= 1'b0;
      resp_byte   <= 8'h00;
      resp_vld    <= 1'b0;
      resp_last   <= 1'b0;
      resp_cnt    <= {LEN_W{1'b0}};
      cmd_sent    <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      tx_done_q  <= tx_done;
      trmt       <= 1'b0;
      clr_rx_rdy <= 1'b0;
      resp_vld   <= 1'b0;
      resp_last  <= 1'b0;
      cmd_sent   <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (send_cmd) begin
            cmd_sh      <= cmd;
            len_q       <= sat_len;
            byte_idx    <= {IW{1'b0}};
            resp_cnt    <= {LEN_W{1'b0}};
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          tx_data <= cmd_sh[CW-1 -: 8];
          trmt    <= 1'b1;
          state   <= S_TX_WAIT;
          if (rx_take) begin
            clr_rx_rdy  <= 1'b1;
            overrun_err <= 1'b1;
          end
        end
        S_TX_WAIT: begin
          if (rx_take) begin
            clr_rx_rdy  <= 1'b1;
            overrun_err <= 1'b1;
          end
          if (tx_done_rise) begin
            if (byte_idx != LAST_IDX) begin
              cmd_sh   <= cmd_sh << 8;
              byte_idx <= byte_idx + IW'(1);
              state    <= S_LOAD;
            end else begin
              cmd_sent <= 1'b1;
              if (len_q == {LEN_W{1'b0}}) begin
                state <= S_FIN;
              end else begin
                state <= S_RX_WAIT;
              end
            end
          end
        end
        S_RX_WAIT: begin
          if (rx_take) begin
            resp_byte  <= rx_data;
            resp_vld   <= 1'b1;
            resp_last  <= (resp_cnt_nxt == len_q);
            resp_cnt   <= resp_cnt_nxt;
            clr_rx_rdy <= 1'b1;
            state      <= S_RX_CLR;
          end else if (tmo_tc) begin
            timeout_err <= 1'b1;
            state       <= S_FIN;
          end
        end
        S_RX_CLR: begin
          if (resp_cnt < len_q) begin
            state <= S_RX_WAIT;
          end else begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DSO_CMD_HOST_ACK_CHECK_EN
  // Acknowledge check: only single-byte responses are judged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nack <= 1'b0;
    end else if ((state == S_IDLE) && send_cmd) begin
      nack <= 1'b0;
    end else if ((state == S_RX_WAIT) && (len_q == LEN_W'(1)) && rx_take) begin
      nack <= (rx_data != ACK_BYTE);
    end else if ((state == S_RX_WAIT) && (len_q == LEN_W'(1)) && tmo_tc) begin
      nack <= 1'b1;
    end else begin
      nack <= nack;
    end
  end
`endif

endmodule

// File: tb/tb_dso_cmd_host_seq.sv
// Scoreboard bench for dso_cmd_host_seq with a UART byte-level model.
module tb_dso_cmd_host_seq;

  localparam int CB = 3;
  localparam int RM = 512;
  localparam int TO = 200;
  localparam int LW = $clog2(RM + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [23:0]   cmd;
  logic [LW-1:0] resp_len;
  logic          send_cmd;
  logic          busy;
  logic [7:0]    tx_data;
  logic          trmt;
  logic          tx_done;
  logic [7:0]    rx_data;
  logic          rx_rdy;
  logic          clr_rx_rdy;
  logic [7:0]    resp_byte;
  logic          resp_vld;
  logic          resp_last;
  logic [LW-1:0] resp_cnt;
  logic          cmd_sent;
  logic          done;
  logic          timeout_err;
  logic          overrun_err;
`ifdef DSO_CMD_HOST_ACK_CHECK_EN
  logic          nack;
`endif

  dso_cmd_host_seq #(.CMD_BYTES(CB), .RESP_MAX(RM), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .resp_len(resp_len), .send_cmd(send_cmd),
    .busy(busy), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
    .resp_byte(resp_byte), .resp_vld(resp_vld), .resp_last(resp_last),
    .resp_cnt(resp_cnt), .cmd_sent(cmd_sent), .done(done),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
`ifdef DSO_CMD_HOST_ACK_CHECK_EN
    , .nack(nack)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [7:0] b; logic last; logic [15:0] cnt; } resp_t;
  typedef struct packed { logic [15:0] cnt; logic to; logic ovr; logic nk; } done_t;

  logic [7:0] exp_tx[$];
  resp_t      exp_resp[$];
  done_t      exp_done[$];
  logic [7:0] rx_q[$];

  int   errors = 0;
  int   checks = 0;
  int   tx_count = 0;
  int   cmd_sent_cnt = 0;
  int   ref_cyc = 0;
  int   rx_gap_max = 3;
  logic prev_to = 1'b0;
  resp_t mon_r;
  done_t mon_d;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Transmitter model: acknowledge every strobe after a random latency.
  initial begin
    int lat;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (trmt && !rst) begin
        lat = int'($urandom_range(2, 6));
        repeat (lat) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // Receiver model: present queued bytes, hold rx_rdy until cleared.
  initial begin
    int gap;
    gap = 0;
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (clr_rx_rdy) begin
        rx_rdy = 1'b0;
      end else if (gap > 0) begin
        gap--;
      end else if (!rx_rdy && rx_q.size() > 0) begin
        rx_data = rx_q.pop_front();
        rx_rdy = 1'b1;
        gap = int'($urandom_range(0, rx_gap_max));
      end
    end
  end

  // Monitor: pop expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    if (rst) begin
      cmd_sent_cnt = 0;
      prev_to = 1'b0;
    end else begin
      if (trmt) begin
        tx_count++;
        chk("busy_during_tx", busy, 1);
        if (exp_tx.size() == 0) chk("tx_unexpected_bytes", exp_tx.size() + 1, 0);
        else chk("tx_data", tx_data, exp_tx.pop_front());
      end
      if (cmd_sent) begin
        cmd_sent_cnt++;
        ref_cyc = cyc;
      end
      if (resp_vld) begin
        ref_cyc = cyc;
        if (exp_resp.size() == 0) chk("resp_unexpected", exp_resp.size() + 1, 0);
        else begin
          mon_r = exp_resp.pop_front();
          chk("resp_byte", resp_byte, mon_r.b);
          chk("resp_last", resp_last, mon_r.last);
          chk("resp_cnt", resp_cnt, mon_r.cnt);
        end
      end
      if (timeout_err && !prev_to) chk("timeout_gap", cyc - ref_cyc, TO);
      prev_to = timeout_err;
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", exp_done.size() + 1, 0);
        else begin
          mon_d = exp_done.pop_front();
          chk("done_resp_cnt", resp_cnt, mon_d.cnt);
          chk("done_timeout_err", timeout_err, mon_d.to);
          chk("done_overrun_err", overrun_err, mon_d.ovr);
          chk("done_busy", busy, 0);
          chk("done_cmd_sent_pulses", cmd_sent_cnt, 1);
`ifdef DSO_CMD_HOST_ACK_CHECK_EN
          chk("done_nack", nack, mon_d.nk);
`endif
        end
        cmd_sent_cnt = 0;
      end
    end
  end

  task automatic wait_cmd_sent();
    int k = 0;
    while (!cmd_sent && k < 200) begin @(negedge clk); k++; end
    chk("cmd_sent_seen", cmd_sent, 1);
  endtask

  // One transaction: push expectations, drive request, act as the scope.
  // mode: 0 random bytes, 1 ramp i%256, 2 fixed byte.
  task automatic do_txn(input logic [23:0] c, input int len, input int nsend,
                        input bit ovr, input int mode, input logic [7:0] fixed_b);
    int sat, ns, k, base, budget;
    logic [7:0] data[$];
    logic [7:0] b;
    logic [31:0] rv;
    resp_t r;
    done_t d;
    sat = (len > RM) ? RM : len;
    ns  = (nsend > sat) ? sat : nsend;
    for (int i = 0; i < ns; i++) begin
      rv = $urandom;
      if (mode == 1) b = i[7:0];
      else if (mode == 2) b = fixed_b;
      else b = rv[7:0];
      data.push_back(b);
      r.b = b; r.last = (i + 1 == sat); r.cnt = 16'(i + 1);
      exp_resp.push_back(r);
    end
    d.cnt = 16'(ns); d.to = (ns < sat); d.ovr = ovr; d.nk = 1'b0;
    if (sat == 1) begin
      if (ns == 0) d.nk = 1'b1;
      else d.nk = (data[0] != 8'hA5);
    end
    exp_done.push_back(d);
    exp_tx.push_back(c[23:16]); exp_tx.push_back(c[15:8]); exp_tx.push_back(c[7:0]);

    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    base = tx_count;
    cmd = c; resp_len = LW'(len); send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    if (ovr) begin
      k = 0;
      while (tx_count < base + 2 && k < 100) begin @(negedge clk); k++; end
      rx_gap_max = 0;
      rv = $urandom;
      rx_q.push_back(rv[7:0]);
    end
    wait_cmd_sent();
    rx_gap_max = 3;
    foreach (data[i]) rx_q.push_back(data[i]);
    budget = ns * 10 + 2 * TO + 50;
    k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    chk("done_seen", done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_flags"}, {busy, trmt, clr_rx_rdy, resp_vld, resp_last, cmd_sent,
                          done, timeout_err, overrun_err}, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_resp_byte"}, resp_byte, 0);
    chk({tag, "_resp_cnt"}, resp_cnt, 0);
`ifdef DSO_CMD_HOST_ACK_CHECK_EN
    chk({tag, "_nack"}, nack, 0);
`endif
  endtask

  // Request while busy is dropped; reset in RX_WAIT clears everything at once.
  task automatic reset_test();
    resp_t r;
    int k;
    exp_tx.push_back(8'h05); exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
    r.b = 8'h5C; r.last = 1'b0; r.cnt = 16'd1;
    exp_resp.push_back(r);
    cmd = 24'h051234; resp_len = LW'(4); send_cmd = 1'b1;
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    cmd = 24'hFFFFFF; resp_len = LW'(0);
    @(negedge clk);
    send_cmd = 1'b0;
    wait_cmd_sent();
    rx_q.push_back(8'h5C);
    k = 0;
    while (!resp_vld && k < 50) begin @(negedge clk); k++; end
    chk("rst_test_resp_seen", resp_vld, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rnd;
    int len, nsend, mode, sel;
    bit ovr;
    rst = 1'b0; send_cmd = 1'b0; cmd = 24'h0; resp_len = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_txn(24'h082ABB, 1, 1, 1'b0, 2, 8'hA5);
    do_txn(24'h010000, 510, 510, 1'b0, 1, 8'h00);
    rnd = $urandom; do_txn(rnd[23:0], 4, 2, 1'b0, 0, 8'h00);
    rnd = $urandom; do_txn(rnd[23:0], 2, 2, 1'b1, 0, 8'h00);
    rnd = $urandom; do_txn(rnd[23:0], 1, 1, 1'b0, 2, 8'hA5);
    do_txn(24'h010203, 700, 700, 1'b0, 1, 8'h00);
    do_txn(24'h090010, 1, 1, 1'b0, 2, 8'hEE);
    do_txn(24'h090011, 1, 1, 1'b0, 2, 8'hA5);
    do_txn(24'h030080, 0, 0, 1'b0, 0, 8'h00);
    do_txn(24'h090012, 1, 0, 1'b0, 0, 8'h00);
    reset_test();
    do_txn(24'h082ABB, 1, 1, 1'b0, 2, 8'hA5);

    for (int it = 0; it < 14; it++) begin
      rnd = $urandom;
      sel = int'($urandom_range(0, 5));
      if (sel == 0) len = 0;
      else if (sel == 1) len = 1;
      else if (sel == 2) len = 2;
      else len = int'($urandom_range(3, 24));
      if (len > 0 && $urandom_range(0, 4) == 0) nsend = int'($urandom_range(0, len - 1));
      else nsend = len;
      ovr = ($urandom_range(0, 3) == 0);
      mode = 0;
      if (len == 1) mode = 2;
      do_txn(rnd[23:0], len, nsend, ovr, mode, ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'hEE);
    end

    repeat (10) @(negedge clk);
    chk("exp_tx_drained", exp_tx.size(), 0);
    chk("exp_resp_drained", exp_resp.size(), 0);
    chk("exp_done_drained", exp_done.size(), 0);
    chk("rx_q_drained", rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
